// File: rtl/dipswitch_debouncer.sv
// ---------------------------------------------------------------------------
// dipswitch_debouncer
//
// Purpose:
//   Takes the 64 raw board DIP-switch pins and turns them into eight clean
//   8-bit bank values for the DIP-switch bus driver. Each pin goes through a
//   two-flop synchroniser. Each 8-bit bank is then debounced as a unit.
//   A new bank value is accepted only after it has been seen unchanged for
//   DEBOUNCE_CYCLES consecutive synchronised samples. The block also reports
//   updates for the interrupt/status logic as a one-cycle pulse, a per-bank
//   mask and a sticky pending flag.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive identical samples needed to accept a bank
//                     value (2 .. 2^20)
//   CNT_W           : debounce counter width, 2^CNT_W >= DEBOUNCE_CYCLES
//
// Ports:
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous active-low reset
//   raw_sw       in  64  unsynchronised switch pins, bank b = raw_sw[8b+7:8b]
//   chg_ack      in   1  single-cycle clear for chg_pending
//   dip_switch0
//   ..
//   dip_switch7  out  8  debounced stable bank values
//   chg_pulse    out  1  one-cycle strobe when any bank's stable value updates
//   chg_bank     out  8  banks updated at that edge, zero when chg_pulse is low
//   chg_pending  out  1  sticky update flag, cleared by chg_ack
//
// All outputs are driven directly from flops. There is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module dipswitch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] raw_sw,
    input  logic        chg_ack,
    output logic [7:0]  dip_switch0,
    output logic [7:0]  dip_switch1,
    output logic [7:0]  dip_switch2,
    output logic [7:0]  dip_switch3,
    output logic [7:0]  dip_switch4,
    output logic [7:0]  dip_switch5,
    output logic [7:0]  dip_switch6,
    output logic [7:0]  dip_switch7,
    output logic        chg_pulse,
    output logic [7:0]  chg_bank,
    output logic        chg_pending
);

    localparam int NUM_BANKS = 8;

    // The counter value at which the window is complete. It reaches this
    // value on the N-th identical sample, counting the sample that loaded
    // the candidate as sample 1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchroniser stages. s2 is the first stage that is safe to use.
    logic [63:0] s1;
    logic [63:0] s2;

    // Per-bank debounce state. A packed 2-D layout lets one loop walk all
    // banks while each bank's logic stays fully independent.
    logic [NUM_BANKS-1:0][7:0]       s2_bank;
    logic [NUM_BANKS-1:0][7:0]       cand;
    logic [NUM_BANKS-1:0][7:0]       stable;
    logic [NUM_BANKS-1:0][CNT_W-1:0] cnt;

    // Per-bank decode of the current state.
    logic [NUM_BANKS-1:0] differs;
    logic [NUM_BANKS-1:0] settled;
    logic [NUM_BANKS-1:0] window_done;
    logic [NUM_BANKS-1:0] upd;

    assign s2_bank = s2;

    // Two-flop synchroniser on every raw pin. The pins are asynchronous to
    // clk, so nothing downstream may look at s1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_sw;
            s2 <= s1;
        end
    end

    // Decode each bank's situation in the same priority order the bank
    // register uses. A bank updates only when the sample still matches the
    // candidate and the candidate differs from the stable value. The window
    // must also have run its full length. Any mismatch wins over a
    // completed window, so a bounce on the final cycle still restarts it.
    always_comb begin
        differs     = '0;
        settled     = '0;
        window_done = '0;
        upd         = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            differs[b]     = (s2_bank[b] != cand[b]);
            settled[b]     = (cand[b] == stable[b]);
            window_done[b] = (cnt[b] == CNT_LAST);
            upd[b]         = !differs[b] && !settled[b] && window_done[b];
        end
    end

    // Candidate, counter and stable value per bank.
    // A new sample replaces the candidate and restarts the window. A
    // candidate equal to the stable value has nothing to confirm, so the
    // counter parks at zero. A completed window commits the candidate.
    // Otherwise the counter advances. The counter never wraps, because the
    // commit step returns it to zero first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (differs[b]) begin
                    cand[b] <= s2_bank[b];
                    cnt[b]  <= '0;
                end else if (settled[b]) begin
                    cnt[b]  <= '0;
                end else if (window_done[b]) begin
                    stable[b] <= cand[b];
                    cnt[b]    <= '0;
                end else begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    // Change reporting. The pulse and mask are registered alongside the
    // stable value, so they appear on the same edge as the new data.
    // An update always wins over a simultaneous chg_ack. This ensures an
    // event arriving while software acknowledges the previous one is never
    // lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chg_pulse   <= 1'b0;
            chg_bank    <= '0;
            chg_pending <= 1'b0;
        end else begin
            chg_pulse <= |upd;
            chg_bank  <= upd;
            if (|upd) begin
                chg_pending <= 1'b1;
            end else if (chg_ack) begin
                chg_pending <= 1'b0;
            end
        end
    end

    assign dip_switch0 = stable[0];
    assign dip_switch1 = stable[1];
    assign dip_switch2 = stable[2];
    assign dip_switch3 = stable[3];
    assign dip_switch4 = stable[4];
    assign dip_switch5 = stable[5];
    assign dip_switch6 = stable[6];
    assign dip_switch7 = stable[7];

endmodule

// File: tb/tb_dipswitch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_dipswitch_debouncer
//
// Directed bench for dipswitch_debouncer with DEBOUNCE_CYCLES = 4.
// Whenever a raw value is driven that should eventually be accepted, an
// expected update (due edge, bank mask, values) is pushed to a scoreboard
// queue. After every rising edge the outputs are checked on the following
// falling edge. If the queue head is due, the expected stable values,
// pulse, mask and pending flag are taken from it. Otherwise no pulse is
// expected and the stable values must hold.
// ---------------------------------------------------------------------------
module tb_dipswitch_debouncer;

    localparam int N_DEB = 4;
    localparam int LATENCY = N_DEB + 2;

    typedef struct {
        int          due;
        logic [7:0]  mask;
        logic [63:0] vals;
    } sb_entry_t;

    logic        clk;
    logic        reset;
    logic [63:0] raw_sw;
    logic        chg_ack;
    logic [7:0]  dip_switch0, dip_switch1, dip_switch2, dip_switch3;
    logic [7:0]  dip_switch4, dip_switch5, dip_switch6, dip_switch7;
    logic        chg_pulse;
    logic [7:0]  chg_bank;
    logic        chg_pending;
    logic [63:0] dip_all;

    sb_entry_t   sb_q[$];
    int          edge_cnt;
    int          tests_run;
    int          tests_failed;
    logic [63:0] cur_raw;
    logic [63:0] exp_stable;
    logic        exp_pulse;
    logic [7:0]  exp_bank;
    logic        exp_pending;

    dipswitch_debouncer #(
        .DEBOUNCE_CYCLES(N_DEB),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_sw(raw_sw),
        .chg_ack(chg_ack),
        .dip_switch0(dip_switch0),
        .dip_switch1(dip_switch1),
        .dip_switch2(dip_switch2),
        .dip_switch3(dip_switch3),
        .dip_switch4(dip_switch4),
        .dip_switch5(dip_switch5),
        .dip_switch6(dip_switch6),
        .dip_switch7(dip_switch7),
        .chg_pulse(chg_pulse),
        .chg_bank(chg_bank),
        .chg_pending(chg_pending)
    );

    assign dip_all = {dip_switch7, dip_switch6, dip_switch5, dip_switch4,
                      dip_switch3, dip_switch2, dip_switch1, dip_switch0};

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string tag, input logic [63:0] observed,
                           input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance the model for the edge just taken, then compare all outputs.
    task automatic checkOutput(input logic ack_seen);
        sb_entry_t e;
        if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
            e = sb_q.pop_front();
            for (int b = 0; b < 8; b++) begin
                if (e.mask[b]) exp_stable[b*8 +: 8] = e.vals[b*8 +: 8];
            end
            exp_pulse   = 1'b1;
            exp_bank    = e.mask;
            exp_pending = 1'b1;
        end else begin
            exp_pulse = 1'b0;
            exp_bank  = 8'h00;
            if (ack_seen) exp_pending = 1'b0;
        end
        compare($sformatf("dip_switch@%0d", edge_cnt), dip_all, exp_stable);
        compare($sformatf("chg_pulse@%0d", edge_cnt), 64'(chg_pulse), 64'(exp_pulse));
        compare($sformatf("chg_bank@%0d", edge_cnt), 64'(chg_bank), 64'(exp_bank));
        compare($sformatf("chg_pending@%0d", edge_cnt), 64'(chg_pending), 64'(exp_pending));
    endtask

    // One rising edge, then check on the falling edge that follows.
    task automatic step(input int count);
        logic ack_seen;
        for (int i = 0; i < count; i++) begin
            ack_seen = chg_ack;
            @(posedge clk);
            edge_cnt++;
            @(negedge clk);
            checkOutput(ack_seen);
        end
    endtask

    // Drive a new raw value at a falling edge. Banks in upd_mask are
    // expected to be accepted LATENCY edges after the next rising edge.
    task automatic applyStimulus(input logic [63:0] value, input logic [7:0] upd_mask);
        sb_entry_t e;
        cur_raw = value;
        raw_sw  = value;
        if (upd_mask != 8'h00) begin
            e.due  = edge_cnt + 1 + LATENCY;
            e.mask = upd_mask;
            e.vals = value;
            sb_q.push_back(e);
        end
    endtask

    task automatic clearModel();
        sb_q.delete();
        exp_stable  = '0;
        exp_pulse   = 1'b0;
        exp_bank    = 8'h00;
        exp_pending = 1'b0;
    endtask

    initial begin
        logic [7:0] nz_mask;
        tests_run    = 0;
        tests_failed = 0;
        edge_cnt     = 0;
        reset        = 1'b0;
        raw_sw       = '0;
        cur_raw      = '0;
        chg_ack      = 1'b0;
        clearModel();

        // Reset state at power-up, before any clock edge.
        #2;
        checkOutput(1'b0);
        @(negedge clk);
        step(2);
        reset = 1'b1;
        step(3);

        // Clean change on bank 0.
        applyStimulus({cur_raw[63:8], 8'hA5}, 8'h01);
        step(8);

        // Three-cycle glitch on bank 3 that returns to 0x00: no update.
        applyStimulus({cur_raw[63:32], 8'hFF, cur_raw[23:0]}, 8'h00);
        step(3);
        applyStimulus({cur_raw[63:32], 8'h00, cur_raw[23:0]}, 8'h00);
        step(8);

        // Bounce on bank 3 with two-cycle spacing, then settle at 0xFF.
        applyStimulus({cur_raw[63:32], 8'hFF, cur_raw[23:0]}, 8'h00);
        step(2);
        applyStimulus({cur_raw[63:32], 8'h00, cur_raw[23:0]}, 8'h00);
        step(2);
        applyStimulus({cur_raw[63:32], 8'hFF, cur_raw[23:0]}, 8'h08);
        step(8);

        // Plain acknowledge clears the pending flag.
        chg_ack = 1'b1;
        step(1);
        chg_ack = 1'b0;
        step(1);

        // Banks 0 and 7 change on the same edge.
        applyStimulus({8'h81, cur_raw[55:8], 8'h3C}, 8'h81);
        step(8);

        chg_ack = 1'b1;
        step(1);
        chg_ack = 1'b0;
        step(1);

        // Acknowledge on the same edge as an update: the update wins.
        applyStimulus({cur_raw[63:48], 8'h5A, cur_raw[39:0]}, 8'h20);
        step(LATENCY);
        chg_ack = 1'b1;
        step(1);
        chg_ack = 1'b0;
        step(2);
        chg_ack = 1'b1;
        step(1);
        chg_ack = 1'b0;
        step(2);

        // Reset in the middle of a bank 2 window.
        applyStimulus({cur_raw[63:24], 8'h77, cur_raw[15:0]}, 8'h00);
        step(3);
        reset = 1'b0;
        #1;
        clearModel();
        checkOutput(1'b0);
        step(2);
        reset = 1'b1;
        // Every bank that is non-zero at release reports itself once.
        nz_mask = 8'h00;
        for (int b = 0; b < 8; b++) nz_mask[b] = (cur_raw[b*8 +: 8] != 8'h00);
        applyStimulus(cur_raw, nz_mask);
        step(9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
